// File: rtl/fifo_uart_tx.sv
`timescale 1ns/1ps
// fifo_uart_tx: pulls bytes from a FIFO with registered read data and
// serialises them as 8N1 frames, LSB first, at CLKS_PER_BIT clocks per bit.
// Optional macro FIFO_UART_TX_PARITY_EN adds an even-parity bit before STOP.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       empty,
    output logic       re,
    input  logic [7:0] in,
    output logic       txd,
    output logic       busy
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] START  = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd4;
`endif
    localparam logic [2:0] STOP   = 3'd5;

    logic [2:0]    state;
    logic [CW-1:0] baud;
    logic [2:0]    bitcnt;
    logic [7:0]    sh;
    logic          baud_done;

    assign baud_done = (baud == BAUD_MAX);

    // Read strobe and busy flag; re is gated by rst so it stays low during reset.
    always_comb begin
        re   = rst && (state == IDLE) && en && !empty;
        busy = (state != IDLE);
    end

    // Frame sequencer; txd is loaded with the level of the state being entered
    // so the line is registered. The shift register rotates rather than
    // shifts, so after 8 bits it holds the original byte for the parity XOR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            baud   <= '0;
            bitcnt <= '0;
            sh     <= '0;
            txd    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (re) begin
                        state <= FETCH;
                        baud  <= '0;
                    end
                end
                FETCH: begin
                    sh    <= in;
                    txd   <= 1'b0;
                    state <= START;
                    baud  <= '0;
                end
                START: begin
                    if (baud_done) begin
                        state <= DATA;
                        baud  <= '0;
                        txd   <= sh[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud   <= '0;
                        sh     <= {sh[0], sh[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                            state <= PARITY;
                            txd   <= ^sh;
`else
                            state <= STOP;
                            txd   <= 1'b1;
`endif
                        end else begin
                            txd <= sh[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_done) begin
                        state <= STOP;
                        baud  <= '0;
                        txd   <= 1'b1;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_done) begin
                        state <= IDLE;
                        baud  <= '0;
                        txd   <= 1'b1;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    baud  <= '0;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule
